ahb_dma_slv_if: RTL

AHB-Lite slave front-end for the DMA controller's register file. It converts pipelined AHB address and data phases into the register file's single-cycle write strobe and registered-read request. It returns read data, inserts wait states, and generates ERROR responses. It sits between the system AHB interconnect (HSEL decoded externally) and the DMA register file.

---
 rtl/ahb_dma_pkg.sv | 24 ++
 rtl/ahb_dma_slv_if.sv | 107 ++++++++++
 2 files changed

// File: rtl/ahb_dma_pkg.sv
// Shared AHB-Lite encodings and the slave-interface state type for the DMA
// controller's bus front-end.
package ahb_dma_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RDATA,
        ST_RSTALL,
        ST_ERR1,
        ST_ERR2
    } dma_slv_state_t;

endpackage

// File: rtl/ahb_dma_slv_if.sv
// AHB-Lite slave front-end for the DMA register file: turns AHB address/data
// phases into a write strobe and a registered-read request, with ERROR replies.
module ahb_dma_slv_if
    import ahb_dma_pkg::*;
#(
    parameter int channel_number = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [7:0]  ahb_address,
    output logic [31:0] ahb_write_data,
    output logic        ahb_write_enable,
    output logic [7:0]  ahb_read_address,
    output logic        ahb_read_enable,
    input  logic [31:0] ahb_read_data
);

    localparam logic [4:0] MAX_BLOCK = 5'(channel_number);

    dma_slv_state_t state, next_state;
    logic [7:0]     cap_idx;
    logic           capture;
    logic [7:0]     idx;
    logic           acc;
    logic           can_accept;
    logic           new_phase;
    logic           legal;
    logic           unused_ok;

    assign idx        = HADDR[9:2];
    assign acc        = HSEL & HREADY & HTRANS[1];
    assign can_accept = (state == ST_IDLE) || (state == ST_WDATA) ||
                        (state == ST_RDATA) || (state == ST_ERR2);
    // Gated by rst so a held address phase cannot strobe while reset is asserted.
    assign new_phase  = acc & can_accept & rst;
    assign legal      = (HSIZE == HSIZE_WORD) && (HADDR[1:0] == 2'b00) &&
                        (idx[7:3] <= MAX_BLOCK);
    assign unused_ok  = &{1'b0, HADDR[31:10], HTRANS[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cap_idx <= 8'h00;
        end else begin
            state <= next_state;
            if (capture) begin
                cap_idx <= idx;
            end
        end
    end

    // A read arriving during WDATA is deferred one cycle so it sees the write.
    always_comb begin
        next_state       = state;
        capture          = 1'b0;
        ahb_read_enable  = 1'b0;
        ahb_read_address = 8'h00;
        unique case (state)
            ST_ERR1: begin
                next_state = ST_ERR2;
            end
            ST_RSTALL: begin
                next_state       = ST_RDATA;
                ahb_read_enable  = 1'b1;
                ahb_read_address = cap_idx;
            end
            default: begin
                if (new_phase) begin
                    if (!legal) begin
                        next_state = ST_ERR1;
                    end else if (HWRITE) begin
                        next_state = ST_WDATA;
                        capture    = 1'b1;
                    end else if (state == ST_WDATA) begin
                        next_state = ST_RSTALL;
                        capture    = 1'b1;
                    end else begin
                        next_state       = ST_RDATA;
                        ahb_read_enable  = 1'b1;
                        ahb_read_address = idx;
                    end
                end else begin
                    next_state = ST_IDLE;
                end
            end
        endcase
    end

    assign ahb_write_enable = (state == ST_WDATA);
    assign ahb_address      = (state == ST_WDATA) ? cap_idx : 8'h00;
    assign ahb_write_data   = (state == ST_WDATA) ? HWDATA : 32'h0;

    assign HREADYOUT = !((state == ST_RSTALL) || (state == ST_ERR1));
    assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (state == ST_RDATA) ? ahb_read_data : 32'h0;

endmodule
